// File: rtl/data_bus_arbiter_pkg.sv
// Shared types and constants for the data_bus_arbiter block.
package data_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    IDLE       = 2'd1,
    STROBE     = 2'd2,
    GAP        = 2'd3
  } state_e;

  localparam int NUM_REQ_DEF      = 3;
  localparam int WIDTH_DEF        = 8;
  localparam int RESET_CYCLES_DEF = 16;
  localparam int HOLD_CYCLES_DEF  = 4;

  // Bits needed to count 0 .. max_count-1, never less than one.
  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/data_bus_arbiter_rr.sv
// Round-robin request selector with its pointer register.
// DATA_BUS_ARBITER_FIXED_PRIORITY_EN: lowest index always wins, no pointer.
module rr_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ_P = NUM_REQ_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ_P-1:0]             req,
  input  logic                             advance,
  input  logic [cnt_width(NUM_REQ_P)-1:0]  winner,
  output logic [NUM_REQ_P-1:0]             grant
);

  localparam int IDX_W = cnt_width(NUM_REQ_P);
  localparam logic [NUM_REQ_P-1:0] ONE = NUM_REQ_P'(1);

`ifdef DATA_BUS_ARBITER_FIXED_PRIORITY_EN
  logic unused_sink;
  assign unused_sink = ^{clk, rst, advance, winner};

  always_comb begin
    grant = '0;
    for (int k = NUM_REQ_P - 1; k >= 0; k--) begin
      if (req[k]) grant = ONE << k;
    end
  end
`else
  logic [IDX_W-1:0]       ptr;
  logic [2*NUM_REQ_P-1:0] req_dbl;
  int                     sum;

  // Doubling the vector makes the wrap-around search a plain priority scan.
  assign req_dbl = {req, req} >> ptr;

  always_comb begin
    grant = '0;
    sum   = 0;
    for (int k = NUM_REQ_P - 1; k >= 0; k--) begin
      if (req_dbl[k]) begin
        sum = int'(ptr) + k;
        if (sum >= NUM_REQ_P) sum = sum - NUM_REQ_P;
        grant = ONE << sum;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (winner == IDX_W'(NUM_REQ_P - 1)) ? '0 : winner + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/data_bus_arbiter.sv
// Shares one byte-wide strobe bus among requesters with a post-reset hold and per-byte gap.
// DATA_BUS_ARBITER_FIXED_PRIORITY_EN selects fixed priority instead of round-robin.
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ_P      = NUM_REQ_DEF,
  parameter int WIDTH_P        = WIDTH_DEF,
  parameter int RESET_CYCLES_P = RESET_CYCLES_DEF,
  parameter int HOLD_CYCLES_P  = HOLD_CYCLES_DEF
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [NUM_REQ_P-1:0]         valid_i,
  input  logic [NUM_REQ_P*WIDTH_P-1:0] data_i,
  output logic [NUM_REQ_P-1:0]         ready_o,
  output logic [WIDTH_P-1:0]           data_o,
  output logic                         enable_o,
  output logic                         reset_o,
  output logic [NUM_REQ_P-1:0]         grant_o,
  output logic                         busy_o
);

  localparam int IDX_W    = cnt_width(NUM_REQ_P);
  localparam int CNT_W    = cnt_width((RESET_CYCLES_P > HOLD_CYCLES_P) ? RESET_CYCLES_P : HOLD_CYCLES_P);
  localparam int GAP_LAST = (HOLD_CYCLES_P > 1) ? HOLD_CYCLES_P - 2 : 0;

  state_e               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_REQ_P-1:0] arb_grant;
  logic [IDX_W-1:0]     winner;
  logic [WIDTH_P-1:0]   win_dat;
  logic                 xfer;

  rr_arbiter #(.NUM_REQ_P(NUM_REQ_P)) u_rr (
    .clk     (clk_i),
    .rst     (reset_i),
    .req     (valid_i),
    .advance (xfer),
    .winner  (winner),
    .grant   (arb_grant)
  );

  assign xfer = (state == IDLE) && (|arb_grant);

  always_comb begin
    winner  = '0;
    win_dat = '0;
    for (int k = 0; k < NUM_REQ_P; k++) begin
      if (arb_grant[k]) begin
        winner  = IDX_W'(k);
        win_dat = data_i[k*WIDTH_P +: WIDTH_P];
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state   <= RESET_HOLD;
      cnt     <= '0;
      data_o  <= '0;
      grant_o <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt == state && (state == RESET_HOLD || state == GAP)) ? cnt + 1'b1 : '0;
      if (xfer) begin
        data_o  <= win_dat;
        grant_o <= arb_grant;
      end else if (state_nxt == IDLE) begin
        grant_o <= '0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RESET_HOLD: if (cnt == CNT_W'(RESET_CYCLES_P - 1)) state_nxt = IDLE;
      IDLE:       if (xfer) state_nxt = STROBE;
      STROBE:     state_nxt = (HOLD_CYCLES_P == 1) ? IDLE : GAP;
      GAP:        if (cnt == CNT_W'(GAP_LAST)) state_nxt = IDLE;
      default:    state_nxt = RESET_HOLD;
    endcase
  end

  always_comb begin
    ready_o  = (state == IDLE) ? arb_grant : '0;
    enable_o = (state == STROBE);
    reset_o  = (state == RESET_HOLD);
    busy_o   = (state != IDLE);
  end

`ifndef SYNTHESIS
  // A pending request must hold both valid and data until it is accepted.
  for (genvar g = 0; g < NUM_REQ_P; g++) begin : g_req_rule
    a_req_hold: assert property (@(posedge clk_i) disable iff (reset_i)
      (valid_i[g] && !ready_o[g]) |=> (valid_i[g] && $stable(data_i[g*WIDTH_P +: WIDTH_P])));
  end
`endif

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: default build plus a HOLD_CYCLES_P=1 instance.
module tb_data_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [2:0]  valid = '0;
  logic [23:0] data = '0;
  logic [2:0]  ready_o, grant_o;
  logic [7:0]  data_o;
  logic        enable_o, reset_o, busy_o;

  logic [2:0]  valid1 = '0;
  logic [23:0] data1 = {8'h33, 8'h22, 8'h11};
  logic [2:0]  ready1, grant1;
  logic [7:0]  dout1;
  logic        enable1, reset1, busy1;

  int chk = 0;
  int pass = 0;

  always #5 clk = ~clk;

  data_bus_arbiter dut (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid), .data_i(data),
    .ready_o(ready_o), .data_o(data_o), .enable_o(enable_o),
    .reset_o(reset_o), .grant_o(grant_o), .busy_o(busy_o)
  );

  data_bus_arbiter #(.RESET_CYCLES_P(2), .HOLD_CYCLES_P(1)) dut1 (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid1), .data_i(data1),
    .ready_o(ready1), .data_o(dout1), .enable_o(enable1),
    .reset_o(reset1), .grant_o(grant1), .busy_o(busy1)
  );

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_strobe(output bit ok, output logic [7:0] d, output logic [2:0] g);
    ok = 1'b0; d = '0; g = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (enable_o) begin
        ok = 1'b1; d = data_o; g = grant_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n_high, first;
    logic [2:0] rdy_seen;
    bit ok;
    valid = 3'b001;
    data  = {8'h33, 8'h22, 8'h11};
    repeat (2) @(negedge clk);
    chk++; if (reset_o !== 1'b1) $display("FAIL rst_reset_o got=%b exp=1", reset_o); else pass++;
    chk++; if (enable_o !== 1'b0) $display("FAIL rst_enable got=%b exp=0", enable_o); else pass++;
    chk++; if (data_o !== 8'h00) $display("FAIL rst_data got=%h exp=00", data_o); else pass++;
    chk++; if (grant_o !== 3'b000) $display("FAIL rst_grant got=%b exp=000", grant_o); else pass++;
    chk++; if (ready_o !== 3'b000) $display("FAIL rst_ready got=%b exp=000", ready_o); else pass++;
    chk++; if (busy_o !== 1'b1) $display("FAIL rst_busy got=%b exp=1", busy_o); else pass++;
    reset_i = 1'b0;
    #1;
    n_high = 0; first = -1; rdy_seen = '0;
    for (int k = 0; k <= 30; k++) begin
      if (k > 0) @(negedge clk);
      if (reset_o) n_high++;
      if (ready_o !== 3'b000) begin
        first = k; rdy_seen = ready_o;
        break;
      end
    end
    chk++; if (n_high != 16) $display("FAIL hold_len got=%0d exp=16", n_high); else pass++;
    chk++; if (first != 16) $display("FAIL first_ready_cycle got=%0d exp=16", first); else pass++;
    chk++; if (rdy_seen !== 3'b001) $display("FAIL first_ready got=%b exp=001", rdy_seen); else pass++;
    @(negedge clk);
    chk++; if (enable_o !== 1'b1 || data_o !== 8'h11 || grant_o !== 3'b001)
      $display("FAIL first_strobe got en=%b d=%h g=%b exp en=1 d=11 g=001", enable_o, data_o, grant_o);
    else pass++;
    valid = 3'b000;
    wait_idle(ok);
    chk++; if (!ok) $display("FAIL reset_idle_timeout got=busy exp=idle"); else pass++;
  endtask

  task automatic test_single();
    int n, bad, extra;
    data  = {8'h33, 8'hA5, 8'h11};
    valid = 3'b010;
    #1;
    chk++; if (ready_o !== 3'b010) $display("FAIL single_ready got=%b exp=010", ready_o); else pass++;
    @(negedge clk);
    chk++; if (enable_o !== 1'b1 || data_o !== 8'hA5 || grant_o !== 3'b010 || ready_o !== 3'b000)
      $display("FAIL single_strobe got en=%b d=%h g=%b r=%b exp en=1 d=a5 g=010 r=000",
               enable_o, data_o, grant_o, ready_o);
    else pass++;
    valid = 3'b000;
    n = 0; bad = 0; extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (!busy_o) break;
      if (enable_o) extra++;
      if (grant_o !== 3'b010 || data_o !== 8'hA5) bad++;
    end
    chk++; if (n != 4) $display("FAIL single_gap_len got=%0d exp=4", n); else pass++;
    chk++; if (bad != 0 || extra != 0) $display("FAIL single_gap_stable got bad=%0d extra=%0d exp 0/0", bad, extra); else pass++;
    chk++; if (grant_o !== 3'b000 || data_o !== 8'hA5)
      $display("FAIL single_idle got g=%b d=%h exp g=000 d=a5", grant_o, data_o);
    else pass++;
  endtask

  task automatic test_round_robin();
    logic [7:0] got [9];
    int         ts [9];
    logic [7:0] exp_d [9] = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33};
    int  cnt, bad_gap;
    bit  ok;
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    wait_idle(ok);
    chk++; if (!ok) $display("FAIL rr_reset_timeout got=busy exp=idle"); else pass++;
    data  = {8'h33, 8'h22, 8'h11};
    valid = 3'b111;
    cnt = 0;
    for (int c = 1; c <= 80 && cnt < 9; c++) begin
      @(negedge clk);
      if (enable_o) begin
        got[cnt] = data_o; ts[cnt] = c;
        cnt++;
        if (cnt > 6) valid = valid & ~grant_o;
      end
    end
    chk++; if (cnt != 9) $display("FAIL rr_strobe_count got=%0d exp=9", cnt); else pass++;
    for (int i = 0; i < cnt; i++) begin
      chk++; if (got[i] !== exp_d[i]) $display("FAIL rr_data[%0d] got=%h exp=%h", i, got[i], exp_d[i]); else pass++;
    end
    bad_gap = 0;
    for (int i = 1; i < cnt; i++) if (ts[i] - ts[i-1] != 5) bad_gap++;
    chk++; if (bad_gap != 0 || ts[0] != 1)
      $display("FAIL rr_spacing got bad=%0d first=%0d exp bad=0 first=1", bad_gap, ts[0]);
    else pass++;
    valid = 3'b000;
    wait_idle(ok);
  endtask

  task automatic test_wrap();
    bit ok;
    logic [7:0] d;
    logic [2:0] g;
    valid = 3'b010;
    wait_strobe(ok, d, g);
    chk++; if (!ok || g !== 3'b010) $display("FAIL wrap_step1 got g=%b exp=010", g); else pass++;
    valid = 3'b101;
    wait_strobe(ok, d, g);
    chk++; if (!ok || g !== 3'b100 || d !== 8'h33) $display("FAIL wrap_step2 got g=%b d=%h exp g=100 d=33", g, d); else pass++;
    wait_strobe(ok, d, g);
    chk++; if (!ok || g !== 3'b001 || d !== 8'h11) $display("FAIL wrap_step3 got g=%b d=%h exp g=001 d=11", g, d); else pass++;
    valid = 3'b100;
    wait_strobe(ok, d, g);
    chk++; if (!ok || g !== 3'b100) $display("FAIL wrap_step4 got g=%b exp=100", g); else pass++;
    valid = 3'b000;
    wait_idle(ok);
  endtask

  task automatic test_reset_mid_gap();
    bit ok;
    int early;
    logic [7:0] d;
    logic [2:0] g;
    valid = 3'b001;
    wait_strobe(ok, d, g);
    chk++; if (!ok || d !== 8'h11) $display("FAIL midgap_strobe got d=%h exp=11", d); else pass++;
    valid = 3'b000;
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    chk++; if (grant_o !== 3'b000 || data_o !== 8'h00 || reset_o !== 1'b1 || enable_o !== 1'b0 || busy_o !== 1'b1)
      $display("FAIL midgap_reset got g=%b d=%h rst=%b en=%b busy=%b exp 000/00/1/0/1",
               grant_o, data_o, reset_o, enable_o, busy_o);
    else pass++;
    @(negedge clk);
    valid   = 3'b001;
    reset_i = 1'b0;
    early = 0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k <= 16 && enable_o) early++;
    end
    chk++; if (early != 0) $display("FAIL midgap_early_strobe got=%0d exp=0", early); else pass++;
    chk++; if (enable_o !== 1'b1 || data_o !== 8'h11)
      $display("FAIL midgap_rerequest got en=%b d=%h exp en=1 d=11", enable_o, data_o);
    else pass++;
    valid = 3'b000;
    wait_idle(ok);
  endtask

  task automatic test_back_to_back_hold1();
    bit exp_en;
    logic [7:0] exp_d;
    chk++; if (busy1 !== 1'b0) $display("FAIL h1_idle got busy=%b exp=0", busy1); else pass++;
    valid1 = 3'b011;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_en = (k % 2) == 1;
      exp_d  = (k == 1 || k == 5) ? 8'h11 : 8'h22;
      chk++; if (enable1 !== exp_en || (exp_en && dout1 !== exp_d))
        $display("FAIL h1_cycle%0d got en=%b d=%h exp en=%b d=%h", k, enable1, dout1, exp_en, exp_d);
      else pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_reset_mid_gap();
    test_back_to_back_hold1();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
